// File: rtl/pwm_cap_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_STUCK
    } state_t;

    localparam int PERIOD_DEF  = 256;
    localparam int TOL_DEF     = 2;
    localparam int TIMEOUT_DEF = 512;

    // Frame length outside nominal +/- tol.
    function automatic logic out_of_tol(input int len, input int nominal, input int tol);
        return (len > nominal + tol) || (len < nominal - tol);
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser plus registered edge detect: pwm_in to rise/fall in 3 clk_div cycles.
module pwm_sync_edge (
    input  logic clk_div,
    input  logic rst,
    input  logic pwm_in,
    output logic sync_lvl,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_lvl <= 1'b0;
            prev     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            meta     <= pwm_in;
            sync_lvl <= meta;
            prev     <= sync_lvl;
            rise     <= sync_lvl & ~prev;
            fall     <= ~sync_lvl & prev;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM duty decoder with period check and stuck detection; outputs registered one cycle after the edge.
// Optional trend outputs are built when PWM_CAPTURE_TREND_EN is defined, otherwise tied low.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int PERIOD  = PERIOD_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] duty_out,
    output logic       duty_valid,
    output logic       period_err,
    output logic       timeout,
    output logic       trend_up,
    output logic       trend_down
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   TO_CNT   = CW'(TIMEOUT);
    localparam logic [CW-1:0]   DUTY_MAX = CW'(255);

    state_t        state;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] per_cnt;
    logic          sync_lvl;
    logic          rise;
    logic          fall;
    logic          done;
    logic          stuck_hit;
    logic          upd;
    logic [7:0]    new_duty;

    pwm_sync_edge u_sync_edge (
        .clk_div  (clk_div),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .sync_lvl (sync_lvl),
        .rise     (rise),
        .fall     (fall)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // A rising edge always wins over the stuck check, so a frame landing on the limit still completes.
    always_comb begin
        done      = (state == S_LOW) && rise;
        stuck_hit = (state != S_STUCK) && !rise && (per_cnt >= TO_CNT);
        upd       = done || stuck_hit;
        if (done)
            new_duty = (high_cnt > DUTY_MAX) ? 8'hFF : 8'(high_cnt);
        else
            new_duty = sync_lvl ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            high_cnt   <= '0;
            per_cnt    <= '0;
            duty_out   <= 8'h00;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            duty_valid <= upd;
            if (upd)
                duty_out <= new_duty;
            if (done)
                period_err <= out_of_tol(int'(per_cnt), PERIOD, TOL);

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state    <= S_HIGH;
                        high_cnt <= CNT_ONE;
                        per_cnt  <= CNT_ONE;
                    end else if (stuck_hit) begin
                        state   <= S_STUCK;
                        timeout <= 1'b1;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                S_HIGH: begin
                    if (stuck_hit) begin
                        state   <= S_STUCK;
                        timeout <= 1'b1;
                    end else if (fall) begin
                        state   <= S_LOW;
                        per_cnt <= sat_inc(per_cnt);
                    end else begin
                        high_cnt <= sat_inc(high_cnt);
                        per_cnt  <= sat_inc(per_cnt);
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state    <= S_HIGH;
                        high_cnt <= CNT_ONE;
                        per_cnt  <= CNT_ONE;
                    end else if (stuck_hit) begin
                        state   <= S_STUCK;
                        timeout <= 1'b1;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end
                S_STUCK: begin
                    if (rise) begin
                        state    <= S_HIGH;
                        high_cnt <= CNT_ONE;
                        per_cnt  <= CNT_ONE;
                        timeout  <= 1'b0;
                    end else if (fall) begin
                        state    <= S_IDLE;
                        high_cnt <= '0;
                        per_cnt  <= '0;
                        timeout  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PWM_CAPTURE_TREND_EN
    logic [7:0] prev_duty;
    logic       have_prev;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            prev_duty  <= 8'h00;
            have_prev  <= 1'b0;
            trend_up   <= 1'b0;
            trend_down <= 1'b0;
        end else if (upd) begin
            prev_duty <= new_duty;
            have_prev <= 1'b1;
            if (have_prev && (new_duty > prev_duty)) begin
                trend_up   <= 1'b1;
                trend_down <= 1'b0;
            end else if (have_prev && (new_duty < prev_duty)) begin
                trend_up   <= 1'b0;
                trend_down <= 1'b1;
            end
        end
    end
`else
    assign trend_up   = 1'b0;
    assign trend_down = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: frame decode, period error, trend, reset and stuck input.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_TREND_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    logic       clk_div = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [7:0] duty_out;
    logic       duty_valid;
    logic       period_err;
    logic       timeout;
    logic       trend_up;
    logic       trend_down;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;
    int dbl  = 0;
    logic prev_v = 1'b0;

    pwm_capture dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_err (period_err),
        .timeout    (timeout),
        .trend_up   (trend_up),
        .trend_down (trend_down)
    );

    always #5 clk_div = ~clk_div;

    always @(negedge clk_div) begin
        if (duty_valid) begin
            vcnt = vcnt + 1;
            if (prev_v) dbl = dbl + 1;
        end
        prev_v = duty_valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk = nchk + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic frame(input int high, input int period);
        pwm_in = 1'b1;
        cyc(high);
        pwm_in = 1'b0;
        cyc(period - high);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_duty"},  int'(duty_out),   0);
        chk({tag, "_valid"}, int'(duty_valid), 0);
        chk({tag, "_perr"},  int'(period_err), 0);
        chk({tag, "_tmo"},   int'(timeout),    0);
        chk({tag, "_up"},    int'(trend_up),   0);
        chk({tag, "_down"},  int'(trend_down), 0);
    endtask

    task automatic chk_frame(input string tag, input int nv, input int duty, input int perr,
                             input int up, input int down);
        chk({tag, "_nvalid"}, vcnt, nv);
        chk({tag, "_duty"},   int'(duty_out),   duty);
        chk({tag, "_perr"},   int'(period_err), perr);
        chk({tag, "_up"},     int'(trend_up),   up & TR);
        chk({tag, "_down"},   int'(trend_down), down & TR);
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk_div);
        chk_all_zero("reset");
        @(posedge clk_div);
        #1 rst = 1'b0;
        cyc(10);

        // 256-cycle frames, 64 high: first rise only arms the capture.
        frame(64, 256);
        chk("first_rise_no_valid", vcnt, 0);
        frame(64, 256);
        frame(64, 256);
        frame(100, 250);
        chk_frame("p256_h64", 3, 64, 0, 0, 0);
        frame(100, 257);
        chk_frame("p250_h100", 4, 100, 1, 1, 0);
        frame(10, 256);
        chk_frame("p257_h100", 5, 100, 0, 1, 0);

        // Trend sequence 10, 11, 12, 11.
        frame(11, 256);
        chk_frame("duty10", 6, 10, 0, 0, 1);
        frame(12, 256);
        chk_frame("duty11", 7, 11, 0, 1, 0);
        frame(11, 256);
        chk_frame("duty12", 8, 12, 0, 1, 0);
        frame(255, 256);
        chk_frame("duty11b", 9, 11, 0, 0, 1);

        // 255 high then a one-cycle low glitch, then an overlong high clipped to 255.
        frame(300, 310);
        chk_frame("glitch_h255", 10, 255, 0, 1, 0);
        frame(20, 256);
        chk_frame("h300_clip", 11, 255, 1, 1, 0);

        // Reset in the middle of a high phase.
        pwm_in = 1'b1;
        cyc(30);
        chk_frame("pre_reset", 12, 20, 0, 0, 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        pwm_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        frame(50, 256);
        chk("post_reset_no_valid", vcnt, 12);
        frame(60, 256);
        chk_frame("post_reset_first", 13, 50, 0, 0, 0);

        // Input stuck high for 600 cycles.
        pwm_in = 1'b1;
        cyc(505);
        chk("stuck_early_tmo", int'(timeout), 0);
        chk("stuck_early_nvalid", vcnt, 14);
        chk("stuck_early_duty", int'(duty_out), 60);
        cyc(25);
        chk("stuck_tmo", int'(timeout), 1);
        chk("stuck_nvalid", vcnt, 15);
        chk("stuck_duty", int'(duty_out), 255);
        chk("stuck_up", int'(trend_up), TR);
        cyc(70);
        chk("stuck_single_valid", vcnt, 15);
        chk("stuck_tmo_held", int'(timeout), 1);
        pwm_in = 1'b0;
        cyc(10);
        chk("unstuck_tmo", int'(timeout), 0);
        chk("unstuck_nvalid", vcnt, 15);

        chk("valid_one_cycle", dbl, 0);
        chk("trend_exclusive", int'(trend_up & trend_down), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
